block_nest_checker: RTL and testbench

Parametrised successor to the single-pair keyword balance checker. It consumes a stream of 8-bit ASCII characters, splits it into space-delimited words, and matches the words `begin` and `end` case-insensitively. It tracks nesting depth in a saturating-width counter and flags sticky underflow and overflow errors. It sits on the character-stream path of the P1 text-checking datapath and adds an input qualifier, a depth output and error reporting, none of which the earlier checker has.

---
 rtl/block_pkg.sv | 34 +++
 rtl/block_word_matcher.sv | 62 ++++++
 rtl/block_nest_checker.sv | 71 +++++++
 tb/tb_block_nest_checker.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// block_pkg: shared constants and types for the begin/end nesting checker.
//   CH_*      lowercase ASCII letters the matcher looks for
//   CASE_BIT  bit ORed into 'A'..'Z' to fold them to lowercase
//   word_state_t  tokenizer FSM state
//   fold_case()   case-fold one byte; non-letters pass through raw
package block_pkg;

  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;
  localparam logic [7:0] CASE_BIT = 8'h20;

  typedef enum logic [3:0] {
    W_START,
    W_B,
    W_BE,
    W_BEG,
    W_BEGI,
    W_BEGIN,
    W_E,
    W_EN,
    W_END,
    W_OTHER
  } word_state_t;

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5a) return c | CASE_BIT;
    return c;
  endfunction

endpackage

// File: rtl/block_word_matcher.sv
// block_word_matcher: splits the character stream into DELIM-separated
// words and recognises "begin" / "end" case-insensitively.
//   clk, reset   clock, synchronous active-high reset
//   in_valid     qualifies in; idle cycles leave the FSM untouched
//   in           ASCII character
//   is_begin     combinational pulse on the delimiter that closes "begin"
//   is_end       combinational pulse on the delimiter that closes "end"
module block_word_matcher
  import block_pkg::*;
#(
  parameter logic [7:0] DELIM = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       is_begin,
  output logic       is_end
);

  word_state_t state_q, state_d;
  logic [7:0]  ch;
  logic        is_delim;

  // Delimiter is matched on the raw byte; only letters are folded.
  assign ch       = fold_case(in);
  assign is_delim = (in == DELIM);

  always_comb begin
    state_d  = state_q;
    is_begin = 1'b0;
    is_end   = 1'b0;
    if (in_valid) begin
      if (is_delim) begin
        state_d  = W_START;
        is_begin = (state_q == W_BEGIN);
        is_end   = (state_q == W_END);
      end else begin
        state_d = W_OTHER;
        case (state_q)
          W_START: begin
            if (ch == CH_B)      state_d = W_B;
            else if (ch == CH_E) state_d = W_E;
          end
          W_B:    if (ch == CH_E) state_d = W_BE;
          W_BE:   if (ch == CH_G) state_d = W_BEG;
          W_BEG:  if (ch == CH_I) state_d = W_BEGI;
          W_BEGI: if (ch == CH_N) state_d = W_BEGIN;
          W_E:    if (ch == CH_N) state_d = W_EN;
          W_EN:   if (ch == CH_D) state_d = W_END;
          default: state_d = W_OTHER;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= W_START;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/block_nest_checker.sv
// block_nest_checker: begin/end nesting checker on an ASCII stream.
//   clk, reset   clock, synchronous active-high reset
//   in_valid     qualifies in
//   in           ASCII character
//   result       registered: depth == 0 and no error
//   depth        committed nesting depth (DEPTH_W bits)
//   err          sticky underflow/overflow flag, cleared only by reset
module block_nest_checker
  import block_pkg::*;
#(
  parameter int         DEPTH_W = 4,
  parameter logic [7:0] DELIM   = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  logic               is_begin, is_end;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               result_q, result_d;

  block_word_matcher #(.DELIM(DELIM)) u_matcher (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in       (in),
    .is_begin (is_begin),
    .is_end   (is_end)
  );

  // Once err is set the depth is frozen; pulses are simply ignored.
  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    if (!err_q) begin
      if (is_begin) begin
        if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
        else                      err_d   = 1'b1;
      end else if (is_end) begin
        if (depth_q != '0) depth_d = depth_q - 1'b1;
        else               err_d   = 1'b1;
      end
    end
    result_d = (depth_d == '0) && !err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q  <= '0;
      err_q    <= 1'b0;
      result_q <= 1'b1;
    end else begin
      depth_q  <= depth_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign depth  = depth_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_block_nest_checker.sv
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in;

  logic       result4, err4;
  logic [3:0] depth4;
  logic       result2, err2;
  logic [1:0] depth2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Default-width instance and a narrow instance for overflow; shared stream.
  block_nest_checker #(.DEPTH_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(result4), .depth(depth4), .err(err4)
  );

  block_nest_checker #(.DEPTH_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .result(result2), .depth(depth2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the rising edge consumes them.
  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in       = c;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Drop in_valid at the next falling edge; last char has been clocked by then.
  task automatic settle();
    @(negedge clk);
    in_valid = 1'b0;
    in       = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic check4(input string tag, input int d, input bit e, input bit r);
    check({tag, ".depth"},  32'(depth4),  32'(d));
    check({tag, ".err"},    32'(err4),    32'(e));
    check({tag, ".result"}, 32'(result4), 32'(r));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check4("reset", 0, 0, 1);
    check("reset.depth2", 32'(depth2), 0);

    // Basic pair, mixed case
    send_str("BeGiN ");
    settle();
    check4("pair_begin", 1, 0, 0);
    send_str("eNd ");
    settle();
    check4("pair_end", 0, 0, 1);

    // Near-miss word then underflow, then frozen
    send_str("endd ");
    settle();
    check4("endd_ignored", 0, 0, 1);
    send_str("end ");
    settle();
    check4("underflow", 0, 1, 0);
    send_str("begin ");
    settle();
    check4("frozen", 0, 1, 0);

    // Overflow on the 2-bit instance
    do_reset();
    check4("reset2", 0, 0, 1);
    send_str("begin begin begin ");
    settle();
    check("ovf.depth3", 32'(depth2), 3);
    check("ovf.err_pre", 32'(err2), 0);
    send_str("begin ");
    settle();
    check("ovf.err", 32'(err2), 1);
    check("ovf.depth_hold", 32'(depth2), 3);
    check("ovf.result", 32'(result2), 0);
    check4("wide_no_ovf", 4, 0, 0);

    // Gaps and repeated delimiters
    do_reset();
    send_str("be");
    idle(5);
    send_str("gin");
    settle();
    check4("gap_uncommitted", 0, 0, 1);
    send_str("   ");
    settle();
    check4("gap_commit", 1, 0, 0);

    // Non-matching words
    do_reset();
    send_str("beginx xend begi ");
    settle();
    check4("nonmatch", 0, 0, 1);

    // Reset mid-word at depth 2 (reset wins over a valid char)
    do_reset();
    send_str("begin begin begi");
    settle();
    check4("pre_reset", 2, 0, 0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in       = 8'h20;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check4("mid_reset", 0, 0, 1);
    send_str("n ");
    settle();
    check4("after_reset_n", 0, 0, 1);
    send_str("begin ");
    settle();
    check4("after_reset_begin", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
